// File: rtl/control_sumador_pkg.sv
`default_nettype none
// ============================================================================
// Package     : control_sumador_pkg
// Description : Shared types, key codes and helpers for the keypad-to-BCD-adder
//               sequencing controller (control_sumador_bcd).
// Contents    : state_t      - controller state encoding
//               KEY_ENTER    - keypad code for ENTER
//               KEY_CLR      - keypad code for CLR
//               DIGIT_BLANK  - digit code rendered blank by display_mux
//               DISP_ERR     - display pattern shown on timeout
//               is_digit     - true for key codes 0..9
//               blank_leading- replaces leading zero digits (not the LSD)
// Revision    : 1.0 - initial release
// ============================================================================
package control_sumador_pkg;

  typedef enum logic [2:0] {
    ENTRY_A   = 3'd0,
    ENTRY_B   = 3'd1,
    LAUNCH_LD = 3'd2,
    LAUNCH_GO = 3'd3,
    WAIT_SUM  = 3'd4,
    SHOW      = 3'd5
  } state_t;

  localparam logic [3:0]  KEY_ENTER   = 4'hA;
  localparam logic [3:0]  KEY_CLR     = 4'hC;
  localparam logic [3:0]  DIGIT_BLANK = 4'hF;
  localparam logic [15:0] DISP_ERR    = 16'hEEEE;

  function automatic logic is_digit(input logic [3:0] key);
    return (key <= 4'd9);
  endfunction

  // Walk from the MSD down; every zero digit until the first non-zero one is
  // blanked. The LSD is never blanked so a zero value still shows "0".
  function automatic logic [15:0] blank_leading(input logic [15:0] value);
    logic [15:0] result;
    logic        leading;
    result  = value;
    leading = 1'b1;
    for (int i = 3; i >= 1; i--) begin
      if (leading && (value[4*i +: 4] == 4'h0)) begin
        result[4*i +: 4] = DIGIT_BLANK;
      end else begin
        leading = 1'b0;
      end
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/registro_operando_bcd.sv
`default_nettype none
// ============================================================================
// Module      : registro_operando_bcd
// Description : NUM_DIGITS-digit BCD operand shift register. A new digit enters
//               at the LSD and the operand moves up one digit. Digits arriving
//               once NUM_DIGITS are held are dropped. clr_i and shift_i may be
//               asserted together: the register is cleared and the digit is
//               then taken as the first digit of a fresh entry.
// Ports       : clk      - system clock
//               rst      - synchronous reset, active-high
//               clr_i    - clear operand and digit counter
//               shift_i  - shift digit_i into the LSD
//               digit_i  - BCD digit to enter
//               value_o  - operand, MSD in the highest nibble
// Revision    : 1.0 - initial release
// ============================================================================
module registro_operando_bcd #(
  parameter int NUM_DIGITS = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr_i,
  input  logic                    shift_i,
  input  logic [3:0]              digit_i,
  output logic [4*NUM_DIGITS-1:0] value_o
);

  localparam int W  = 4 * NUM_DIGITS;
  localparam int CW = $clog2(NUM_DIGITS + 1);

  logic [W-1:0]  value_q, value_d;
  logic [CW-1:0] count_q, count_d;
  logic [W-1:0]  value_base;
  logic [CW-1:0] count_base;
  logic [W-1:0]  value_shifted;
  logic          full;

  // A single-digit operand has nothing to shift up.
  generate
    if (NUM_DIGITS == 1) begin : g_single_digit
      assign value_shifted = digit_i;
    end else begin : g_multi_digit
      assign value_shifted = {value_base[W-5:0], digit_i};
    end
  endgenerate

  always_comb begin
    value_base = clr_i ? '0 : value_q;
    count_base = clr_i ? '0 : count_q;
    full       = (count_base == CW'(NUM_DIGITS));
    value_d    = value_base;
    count_d    = count_base;
    if (shift_i && !full) begin
      value_d = value_shifted;
      count_d = count_base + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= '0;
      count_q <= '0;
    end else begin
      value_q <= value_d;
      count_q <= count_d;
    end
  end

  assign value_o = value_q;

endmodule
`default_nettype wire

// File: rtl/control_sumador_bcd.sv
`default_nettype none
// ============================================================================
// Module      : control_sumador_bcd
// Description : Sequencing controller between the 4x4 keypad reader and the
//               3-digit BCD adder. Builds operands A and B from key events,
//               pulses load then start_conv, waits for ready, latches the sum
//               and drives the display multiplexer.
// Options     : CONTROL_SUMADOR_LEADING_BLANK_EN - when defined, leading zero
//               digits on disp_bcd (except the LSD) are shown blank (4'hF).
// Ports       : clk        - system clock
//               rst        - synchronous reset, active-high
//               key_value  - key code from keypad reader
//               key_valid  - one-cycle strobe, key_value valid
//               sum_bcd    - adder result {d3,d2,d1,d0}
//               ready      - adder result valid (level)
//               a_bcd      - operand A, MSD highest
//               b_bcd      - operand B, MSD highest
//               load       - one-cycle operand load strobe
//               start_conv - one-cycle start strobe
//               disp_bcd   - 4 digit codes to display_mux
//               busy       - high while an addition is in flight
//               err        - timeout flag
// Revision    : 1.0 - initial release
// ============================================================================
module control_sumador_bcd
  import control_sumador_pkg::*;
#(
  parameter int NUM_DIGITS     = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3:0]              key_value,
  input  logic                    key_valid,
  input  logic [15:0]             sum_bcd,
  input  logic                    ready,
  output logic [4*NUM_DIGITS-1:0] a_bcd,
  output logic [4*NUM_DIGITS-1:0] b_bcd,
  output logic                    load,
  output logic                    start_conv,
  output logic [15:0]             disp_bcd,
  output logic                    busy,
  output logic                    err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_t        state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
  logic [15:0]   res_q, res_d;
  logic [15:0]   disp_q, disp_d;

  logic a_clr, a_shift, b_clr, b_shift;
  logic key_digit, key_enter, key_clr;

  assign key_digit = key_valid && is_digit(key_value);
  assign key_enter = key_valid && (key_value == KEY_ENTER);
  assign key_clr   = key_valid && (key_value == KEY_CLR);

  registro_operando_bcd #(.NUM_DIGITS(NUM_DIGITS)) u_reg_a (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (a_clr),
    .shift_i (a_shift),
    .digit_i (key_value),
    .value_o (a_bcd)
  );

  registro_operando_bcd #(.NUM_DIGITS(NUM_DIGITS)) u_reg_b (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (b_clr),
    .shift_i (b_shift),
    .digit_i (key_value),
    .value_o (b_bcd)
  );

  function automatic logic [15:0] fmt_view(input logic [15:0] value);
`ifdef CONTROL_SUMADOR_LEADING_BLANK_EN
    return blank_leading(value);
`else
    return value;
`endif
  endfunction

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ENTRY_A;
      tmo_q   <= '0;
      err_q   <= 1'b0;
      res_q   <= '0;
      disp_q  <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      res_q   <= res_d;
      disp_q  <= disp_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and operand control
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    res_d   = res_q;
    a_clr   = 1'b0;
    a_shift = 1'b0;
    b_clr   = 1'b0;
    b_shift = 1'b0;
    case (state_q)
      ENTRY_A: begin
        if (key_clr) begin
          a_clr = 1'b1;
        end else if (key_enter) begin
          state_d = ENTRY_B;
          b_clr   = 1'b1;
        end else if (key_digit) begin
          a_shift = 1'b1;
        end
      end
      ENTRY_B: begin
        if (key_clr) begin
          state_d = ENTRY_A;
          a_clr   = 1'b1;
          b_clr   = 1'b1;
        end else if (key_enter) begin
          state_d = LAUNCH_LD;
        end else if (key_digit) begin
          b_shift = 1'b1;
        end
      end
      LAUNCH_LD: begin
        state_d = LAUNCH_GO;
      end
      LAUNCH_GO: begin
        state_d = WAIT_SUM;
        tmo_d   = '0;
      end
      WAIT_SUM: begin
        tmo_d = tmo_q + TW'(1);
        if (key_clr) begin
          state_d = ENTRY_A;
          a_clr   = 1'b1;
          b_clr   = 1'b1;
          res_d   = '0;
          err_d   = 1'b0;
          tmo_d   = '0;
        end else if (ready && (tmo_q != '0)) begin
          // tmo_q == 0 marks the first WAIT_SUM cycle, where ready may still
          // be left over from the previous addition.
          res_d   = sum_bcd;
          state_d = SHOW;
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          state_d = SHOW;
        end
      end
      SHOW: begin
        if (key_clr) begin
          state_d = ENTRY_A;
          a_clr   = 1'b1;
          b_clr   = 1'b1;
          err_d   = 1'b0;
        end else if (key_digit) begin
          // The digit that leaves SHOW is the first digit of the new A.
          state_d = ENTRY_A;
          a_clr   = 1'b1;
          a_shift = 1'b1;
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d = ENTRY_A;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Display selection, registered so it follows state/operands by one cycle
  // --------------------------------------------------------------------------
  always_comb begin
    disp_d = disp_q;
    case (state_q)
      ENTRY_A: disp_d = fmt_view(16'(a_bcd));
      ENTRY_B: disp_d = fmt_view(16'(b_bcd));
      SHOW:    disp_d = err_q ? DISP_ERR : fmt_view(res_q);
      default: disp_d = disp_q;
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  always_comb begin
    load       = (state_q == LAUNCH_LD);
    start_conv = (state_q == LAUNCH_GO);
    busy       = (state_q == LAUNCH_LD) || (state_q == LAUNCH_GO) ||
                 (state_q == WAIT_SUM);
  end

  assign err      = err_q;
  assign disp_bcd = disp_q;

endmodule
`default_nettype wire

// File: doc/control_sumador_bcd.md
Name: control_sumador_bcd

Overview:
- Sequencing controller between the 4x4 keypad reader and the 3-digit BCD adder.
- Assembles operands A and B from debounced key events and issues the adder's load and start_conv strobes.
- Waits for the adder's ready, latches the 4-digit sum, and selects what the display multiplexer shows: A while entering A, B while entering B, then the sum.

Parameters:
- NUM_DIGITS, 3, BCD digits per operand (1..3); operand bus width is 4*NUM_DIGITS.
- TIMEOUT_CYCLES, 1024, cycles allowed in WAIT_SUM for ready before the error flag is raised (>=2).

Ports:
- clk  input  1  system clock (27 MHz)
- rst  input  1  synchronous reset, active-high
- key_value  input  4  key code from keypad reader
- key_valid  input  1  one-cycle strobe, key_value valid
- sum_bcd  input  16  adder result, 4 BCD digits {d3,d2,d1,d0}
- ready  input  1  adder result valid (level)
- a_bcd  output  4*NUM_DIGITS  operand A, most significant digit (MSD) highest
- b_bcd  output  4*NUM_DIGITS  operand B
- load  output  1  one-cycle operand load strobe to adder
- start_conv  output  1  one-cycle start strobe to adder
- disp_bcd  output  16  4 digit codes to display_mux
- busy  output  1  high in LAUNCH_LD, LAUNCH_GO, WAIT_SUM
- err  output  1  timeout flag

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high on rst. All registers update on posedge clk.
- Reset values: state ENTRY_A; a_bcd, b_bcd, result register, disp_bcd all 0; load, start_conv, busy, err all 0; digit counter 0; timeout counter 0.
- Key classes:
  - 0x0-0x9: digit.
  - 0xA: ENTER.
  - 0xC: CLR.
  - 0xB, 0xD, 0xE, 0xF: ignored in every state.
  - A key is acted on only in the cycle key_valid=1.
- Digit entry: a new digit shifts into the least significant digit (LSD) and the operand shifts left by one digit. The digit counter increments. Once NUM_DIGITS digits are held, further digits are ignored. Short entries are therefore zero-padded.
- States and transitions:
  - ENTRY_A:
    - digit -> shift into A.
    - ENTER -> ENTRY_B; digit counter cleared; B cleared.
    - CLR -> A and counter cleared.
  - ENTRY_B:
    - digit -> shift into B.
    - ENTER -> LAUNCH_LD.
    - CLR -> ENTRY_A; A, B, counter cleared.
  - LAUNCH_LD: load=1 for exactly this cycle -> LAUNCH_GO.
  - LAUNCH_GO: start_conv=1 for exactly this cycle -> WAIT_SUM; timeout counter cleared.
  - WAIT_SUM:
    - ready is ignored in the first WAIT_SUM cycle, since a stale ready may remain from the previous sum.
    - From the second cycle, ready=1 -> latch sum_bcd into the result register -> SHOW.
    - Timeout counter reaches TIMEOUT_CYCLES -> err=1 -> SHOW.
    - CLR -> ENTRY_A with everything cleared; no further strobes.
    - Other keys ignored.
  - SHOW:
    - digit -> ENTRY_A; A cleared, then that digit shifted in (A=digit); err cleared.
    - CLR -> ENTRY_A cleared; err cleared.
    - ENTER ignored.
- a_bcd and b_bcd are held stable from ENTRY_B exit until the next ENTRY_A entry. The adder samples them on load.
- disp_bcd, registered, updates one cycle after the state or operand change:
  - ENTRY_A -> {4'h0, A} zero-extended.
  - ENTRY_B -> {4'h0, B}.
  - LAUNCH_LD, LAUNCH_GO, WAIT_SUM -> hold the last value.
  - SHOW -> result register, or 16'hEEEE when err=1.
- load and start_conv are never high together. They are never reissued without a new ENTER in ENTRY_B.
- Reset asserted mid-operation returns all values to reset values on the next edge. Strobes drop immediately at that edge.

Optional Feature:
- Macro: CONTROL_SUMADOR_LEADING_BLANK_EN.
- Defined: in disp_bcd, leading zero digits (MSD down, excluding the LSD) are replaced with 4'hF, which display_mux renders blank. Applies to operand and sum views, not to 16'hEEEE. Example: sum 0x0042 is shown as 0xFF42.
- Undefined: digits are passed unmodified, with zeros shown.

Decomposition:
- Package control_sumador_pkg holds:
  - state enum state_t {ENTRY_A, ENTRY_B, LAUNCH_LD, LAUNCH_GO, WAIT_SUM, SHOW};
  - KEY_ENTER=4'hA, KEY_CLR=4'hC, DIGIT_BLANK=4'hF, DISP_ERR=16'hEEEE;
  - function is_digit.
- One sub-module, registro_operando_bcd: the NUM_DIGITS shift register with clear, shift-enable, digit counter and full flag. It is instantiated twice, for A and B.

Test Plan:
- Keys 1,2,3,A,4,5,6,A; ready rises 5 cycles after start_conv with sum 0x0579:
  - a_bcd=0x123, b_bcd=0x456;
  - load one cycle after the 2nd ENTER, start_conv the next cycle;
  - disp_bcd=0x0579 in SHOW; busy high only between.
- Keys 7,A,9,A -> a_bcd=0x007, b_bcd=0x009; disp during ENTRY_B = 0x0009, or 0xFFF9 with the macro defined.
- Keys 1,2,3,4,5 -> a_bcd=0x123 (4 and 5 ignored); keys B, D, F in ENTRY_A -> no change.
- ready held at 1 from the previous sum at WAIT_SUM entry, then low for 3 cycles, then high -> the first-cycle stale ready is not accepted (no latch in that cycle); sum is latched when ready re-rises.
- TIMEOUT_CYCLES=16, ready never asserted -> err=1 and disp_bcd=0xEEEE after 16 WAIT_SUM cycles; next key 8 -> err=0, state ENTRY_A, a_bcd=0x008.
- CLR during WAIT_SUM, then ready pulses -> state ENTRY_A, A=B=0, no sum latched. rst=1 mid-ENTRY_B -> all outputs at reset values after one edge.
